// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: multi-retire RVFI packetiser and trace FIFO; define RVFI_TRACE_BACKPRESSURE_EN to stall the core instead of dropping
module rvfi_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NRET-1:0]               ret_valid_i,
  input  logic [NRET*XLEN-1:0]          ret_pc_rdata_i,
  input  logic [NRET*XLEN-1:0]          ret_pc_wdata_i,
  input  logic [NRET*32-1:0]            ret_insn_i,
  input  logic [NRET-1:0]               ret_trap_i,
  input  logic [NRET*5-1:0]             ret_rd_addr_i,
  input  logic [NRET*XLEN-1:0]          ret_rd_wdata_i,
  input  logic [NRET-1:0]               ret_ld_i,
  input  logic [NRET-1:0]               ret_st_i,
  input  logic [NRET*2-1:0]             ret_size_i,
  input  logic [NRET*XLEN-1:0]          ret_mem_addr_i,
  input  logic [NRET*XLEN-1:0]          ret_mem_rdata_i,
  input  logic [NRET*XLEN-1:0]          ret_mem_wdata_i,
  output logic                          trc_valid_o,
  input  logic                          trc_ready_i,
  output logic [102+6*XLEN+XLEN/4-1:0]  trc_pkt_o,
  output logic                          core_stall_o,
  output logic [31:0]                   drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int ML = XLEN / 8;
  localparam int PW = 102 + 6 * XLEN + 2 * ML;
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] pkt [NRET];
  logic [AW:0] slot [NRET];
  logic [AW-1:0] waddr [NRET];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, occ, free, n_ret, n_acc, n_drop;
  logic [63:0] order_q, order_d;
  logic [31:0] drop_q, drop_d;
  logic [32:0] drop_sum;
  logic pop;
  for (genvar g = 0; g < NRET; g++) begin : g_ch
    logic tr;
    logic [4:0] rd;
    logic [XLEN-1:0] rdw, rdv, wdv;
    logic [ML-1:0] msk, rm, wm;
    assign tr  = ret_trap_i[g];
    assign rd  = tr ? 5'd0 : ret_rd_addr_i[g*5+:5];
    assign rdw = rd == 5'd0 ? '0 : ret_rd_wdata_i[g*XLEN+:XLEN];
    assign msk = ML'((32'd1 << (32'd1 << ret_size_i[g*2+:2])) - 32'd1);
    assign rm  = ret_ld_i[g] && !tr ? msk : '0;
    assign wm  = ret_st_i[g] && !tr ? msk : '0;
    for (genvar b = 0; b < ML; b++) begin : g_b
      assign rdv[b*8+:8] = rm[b] ? ret_mem_rdata_i[g*XLEN+b*8+:8] : 8'd0;
      assign wdv[b*8+:8] = wm[b] ? ret_mem_wdata_i[g*XLEN+b*8+:8] : 8'd0;
    end
    assign pkt[g] = {order_q + 64'(slot[g]), ret_pc_rdata_i[g*XLEN+:XLEN], ret_pc_wdata_i[g*XLEN+:XLEN],
                     ret_insn_i[g*32+:32], tr, rd, rdw, ret_mem_addr_i[g*XLEN+:XLEN], rm, wm, rdv, wdv};
  end
  // compact valid channels: each gets its rank among the valid ones this cycle
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i]  = n_ret;
      waddr[i] = AW'(wptr_q + n_ret);
      n_ret    = n_ret + (AW+1)'(ret_valid_i[i]);
    end
  end
  assign occ  = wptr_q - rptr_q;
  assign pop  = occ != '0 && trc_ready_i;
  assign free = (AW+1)'(DEPTH) - occ + (AW+1)'(pop);
`ifdef RVFI_TRACE_BACKPRESSURE_EN
  logic stall_q;
  assign n_acc        = stall_q ? '0 : (n_ret > free ? free : n_ret);
  assign core_stall_o = stall_q;
  // stall when the slots left after this cycle could not absorb a full retire group
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) stall_q <= 1'b0;
    else stall_q <= free - n_acc < (AW+1)'(NRET);
`else
  assign n_acc        = n_ret > free ? free : n_ret;
  assign core_stall_o = 1'b0;
`endif
  assign n_drop      = n_ret - n_acc;
  assign wptr_d      = wptr_q + n_acc;
  assign rptr_d      = rptr_q + (AW+1)'(pop);
  assign order_d     = order_q + 64'(n_ret);
  assign drop_sum    = {1'b0, drop_q} + 33'(n_drop);
  assign drop_d      = drop_sum[32] ? '1 : drop_sum[31:0];
  assign trc_valid_o = occ != '0;
  assign trc_pkt_o   = mem_q[rptr_q[AW-1:0]];
  assign drop_cnt_o  = drop_q;
  // pointers, order number and loss counter
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      order_q <= '0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      order_q <= order_d;
      drop_q  <= drop_d;
    end
  // storage: accepted channels land in consecutive slots from the write pointer
  always_ff @(posedge clk_i)
    for (int i = 0; i < NRET; i++)
      if (ret_valid_i[i] && slot[i] < n_acc) mem_q[waddr[i]] <= pkt[i];
endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// tb_rvfi_trace_fifo: scoreboard bench for rvfi_trace_fifo (XLEN=32, NRET=2, DEPTH=16, drop mode)
module tb_rvfi_trace_fifo;
  localparam int PW = 302;
  typedef struct {
    logic v; logic [31:0] pc, npc, insn; logic trap; logic [4:0] rd; logic [31:0] rdw;
    logic ld, st; logic [1:0] sz; logic [31:0] addr, rdat, wdat;
  } ch_t;
  logic clk = 0, rst_n = 0, trc_ready = 0;
  logic [1:0] ret_valid = 0, ret_trap = 0, ret_ld = 0, ret_st = 0;
  logic [63:0] ret_pc_rdata = 0, ret_pc_wdata = 0, ret_insn = 0, ret_rd_wdata = 0;
  logic [63:0] ret_mem_addr = 0, ret_mem_rdata = 0, ret_mem_wdata = 0;
  logic [9:0] ret_rd_addr = 0;
  logic [3:0] ret_size = 0;
  logic trc_valid, core_stall;
  logic [PW-1:0] trc_pkt;
  logic [31:0] drop_cnt;
  ch_t ch [2];
  logic [PW-1:0] sb [$];
  logic [63:0] mord = 0;
  logic [31:0] m_drop = 0;
  int checks = 0, errors = 0;

  rvfi_trace_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .ret_valid_i(ret_valid), .ret_pc_rdata_i(ret_pc_rdata),
    .ret_pc_wdata_i(ret_pc_wdata), .ret_insn_i(ret_insn), .ret_trap_i(ret_trap),
    .ret_rd_addr_i(ret_rd_addr), .ret_rd_wdata_i(ret_rd_wdata), .ret_ld_i(ret_ld),
    .ret_st_i(ret_st), .ret_size_i(ret_size), .ret_mem_addr_i(ret_mem_addr),
    .ret_mem_rdata_i(ret_mem_rdata), .ret_mem_wdata_i(ret_mem_wdata), .trc_valid_o(trc_valid),
    .trc_ready_i(trc_ready), .trc_pkt_o(trc_pkt), .core_stall_o(core_stall), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [63:0] o, input ch_t c);
    logic [3:0] m, rm, wm;
    logic [4:0] rd;
    logic [31:0] rdw, rdd, wdd;
    case (c.sz)
      2'd0: m = 4'h1;
      2'd1: m = 4'h3;
      default: m = 4'hF;
    endcase
    rm = (c.ld && !c.trap) ? m : 4'h0;
    wm = (c.st && !c.trap) ? m : 4'h0;
    rd = c.trap ? 5'd0 : c.rd;
    rdw = (rd == 5'd0) ? 32'd0 : c.rdw;
    for (int b = 0; b < 4; b++) begin
      rdd[b*8+:8] = rm[b] ? c.rdat[b*8+:8] : 8'd0;
      wdd[b*8+:8] = wm[b] ? c.wdat[b*8+:8] : 8'd0;
    end
    return {o, c.pc, c.npc, c.insn, c.trap, rd, rdw, c.addr, rm, wm, rdd, wdd};
  endfunction

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      ret_valid[i] = ch[i].v; ret_trap[i] = ch[i].trap; ret_ld[i] = ch[i].ld; ret_st[i] = ch[i].st;
      ret_pc_rdata[i*32+:32] = ch[i].pc; ret_pc_wdata[i*32+:32] = ch[i].npc;
      ret_insn[i*32+:32] = ch[i].insn; ret_rd_wdata[i*32+:32] = ch[i].rdw;
      ret_rd_addr[i*5+:5] = ch[i].rd; ret_size[i*2+:2] = ch[i].sz;
      ret_mem_addr[i*32+:32] = ch[i].addr; ret_mem_rdata[i*32+:32] = ch[i].rdat;
      ret_mem_wdata[i*32+:32] = ch[i].wdat;
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 2; i++) ch[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic set(input int i, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rdw,
                     input logic trap, input logic ld, input logic st, input logic [1:0] sz);
    ch[i] = '{1'b1, pc, pc + 32'd4, 32'h0000_0013 ^ pc, trap, rd, rdw, ld, st, sz,
              32'h8000_0000 | pc, 32'hA1B2_C3D4 ^ pc, 32'h5566_7788 ^ pc};
  endtask

  // drive one cycle, then check state after that edge and model the following edge
  task automatic cycle(input logic rdy);
    int free;
    @(posedge clk); #1;
    apply();
    trc_ready = rdy;
    @(negedge clk);
    chk("valid", trc_valid, sb.size() != 0);
    chk("stall", core_stall, 1'b0);
    chk("drop", drop_cnt, m_drop);
    if (sb.size() != 0 && trc_ready) chk("pkt", trc_pkt, sb.pop_front());
    free = 16 - sb.size();
    for (int i = 0; i < 2; i++)
      if (ch[i].v) begin
        if (free > 0) begin
          sb.push_back(mk(mord, ch[i]));
          free--;
        end else m_drop++;
        mord++;
      end
  endtask

  task automatic drain();
    clear();
    for (int n = 0; n < 64 && sb.size() != 0; n++) cycle(1'b1);
    cycle(1'b1);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    clear();
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_drop", drop_cnt, 32'd0);
    rst_n = 1;
    set(0, 32'h100, 5'd1, 32'h11, 0, 0, 0, 2'd2);
    set(1, 32'h104, 5'd2, 32'h22, 0, 0, 0, 2'd2);
    cycle(1'b1);
    clear();
    cycle(1'b1);
    chk("first_order_pc", trc_pkt[PW-1-:96], {64'd0, 32'h100});
    drain();
    clear(); set(1, 32'h200, 5'd3, 32'h33, 0, 0, 0, 2'd2); cycle(1'b1);
    clear(); set(0, 32'h300, 5'd4, 32'h44, 0, 0, 0, 2'd2); cycle(1'b1);
    drain();
    clear(); set(0, 32'h400, 5'd5, 32'h1234, 0, 1, 0, 2'd1); set(1, 32'h404, 5'd5, 32'h1234, 1, 1, 0, 2'd1);
    cycle(1'b0);
    clear(); cycle(1'b0);
    chk("lh_masks", trc_pkt[71:64], 8'h30);
    drain();
    clear(); set(0, 32'h500, 5'd0, 32'hDEAD, 0, 0, 0, 2'd2); set(1, 32'h504, 5'd7, 32'h99, 0, 0, 1, 2'd0);
    cycle(1'b1);
    drain();
    for (int c = 0; c < 3; c++) begin
      clear(); set(0, 32'h600 + c * 8, 5'd1, c, 0, 0, 0, 2'd2);
      if (c < 2) set(1, 32'h604 + c * 8, 5'd2, c, 0, 0, 0, 2'd2);
      cycle(1'b0);
    end
    clear(); cycle(1'b0);
    chk("q5_valid", trc_valid, 1'b1);
    #2 rst_n = 0;
    apply();
    #1 chk("async_rst_valid", trc_valid, 1'b0);
    sb.delete(); mord = 0; m_drop = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 9; c++) begin
      clear(); set(0, 32'h1000 + c * 8, 5'd1, c, 0, 0, 0, 2'd2); set(1, 32'h1004 + c * 8, 5'd2, c, 0, 0, 0, 2'd2);
      cycle(1'b0);
    end
    clear(); cycle(1'b0);
    chk("ovf_drop", drop_cnt, 32'd2);
    chk("ovf_head_order", trc_pkt[PW-1-:64], 64'd0);
    drain();
    clear(); set(0, 32'h2000, 5'd3, 32'h7, 0, 0, 0, 2'd2); cycle(1'b1);
    clear(); cycle(1'b1);
    chk("order_after_gap", trc_pkt[PW-1-:64], 64'd18);
    drain();
    for (int c = 0; c < 300; c++) begin
      clear();
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 2) != 0) begin
          set(i, $urandom, 5'($urandom), $urandom, $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), 2'($urandom));
          ch[i].addr = $urandom; ch[i].rdat = $urandom; ch[i].wdat = $urandom;
        end
      cycle($urandom_range(0, 3) == 0);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
